// File: rtl/ula_sequenciador.sv
// Request/response sequencer in front of the combinational ULA.
// Optional macro ULA_SEQ_ENCADEAR_EN adds result chaining into operand A.
module ula_sequenciador #(
    parameter int BITS_PALAVRA  = 16,
    parameter int BITS_CONTADOR = 16
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     req_valido,
    output logic                     req_pronto,
    input  logic [4:0]               req_controle,
    input  logic [BITS_PALAVRA-1:0]  req_opA,
    input  logic [BITS_PALAVRA-1:0]  req_opB,
`ifdef ULA_SEQ_ENCADEAR_EN
    input  logic                     req_encadear,
`endif
    output logic [BITS_PALAVRA-1:0]  ula_operandoA,
    output logic [BITS_PALAVRA-1:0]  ula_operandoB,
    output logic [4:0]               ula_controle,
    input  logic [BITS_PALAVRA-1:0]  ula_resultado,
    input  logic                     ula_Z,
    input  logic                     ula_C,
    input  logic                     ula_S,
    input  logic                     ula_O,
    output logic                     resp_valido,
    input  logic                     resp_pronto,
    output logic [BITS_PALAVRA-1:0]  resp_resultado,
    output logic [3:0]               resp_flags,
    output logic                     resp_erro,
    output logic [3:0]               flags_reg,
    output logic [BITS_CONTADOR-1:0] contador_ops
);

    localparam logic [1:0] OCIOSO   = 2'd0;
    localparam logic [1:0] EMITE    = 2'd1;
    localparam logic [1:0] RESPONDE = 2'd2;

    localparam logic [BITS_CONTADOR-1:0] UM =
        {{(BITS_CONTADOR-1){1'b0}}, 1'b1};

    logic [1:0]              estado;
    logic                    legal;
    logic [BITS_PALAVRA-1:0] opa_sel;

    always_comb begin
        legal = 1'b0;
        case (req_controle)
            5'b00000, 5'b00001, 5'b00011,
            5'b00100, 5'b00101, 5'b00110: legal = 1'b1;
            default:                      legal = 1'b0;
        endcase
    end

`ifdef ULA_SEQ_ENCADEAR_EN
    logic [BITS_PALAVRA-1:0] ultimo;

    assign opa_sel = req_encadear ? ultimo : req_opA;

    // Last legal result, source for chained operand A.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            ultimo <= '0;
        else if (estado == EMITE)
            ultimo <= ula_resultado;
    end
`else
    assign opa_sel = req_opA;
`endif

    // Gated by reset_n so every output reads 0 while reset is held.
    assign req_pronto  = reset_n && (estado == OCIOSO);
    assign resp_valido = (estado == RESPONDE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado         <= OCIOSO;
            ula_operandoA  <= '0;
            ula_operandoB  <= '0;
            ula_controle   <= '0;
            resp_resultado <= '0;
            resp_flags     <= '0;
            resp_erro      <= 1'b0;
            flags_reg      <= '0;
            contador_ops   <= '0;
        end else begin
            unique case (estado)
                OCIOSO: begin
                    if (req_valido) begin
                        if (legal) begin
                            ula_operandoA <= opa_sel;
                            ula_operandoB <= req_opB;
                            ula_controle  <= req_controle;
                            estado        <= EMITE;
                        end else begin
                            resp_resultado <= '0;
                            resp_flags     <= '0;
                            resp_erro      <= 1'b1;
                            estado         <= RESPONDE;
                        end
                    end
                end
                EMITE: begin
                    resp_resultado <= ula_resultado;
                    resp_flags     <= {ula_Z, ula_C, ula_S, ula_O};
                    resp_erro      <= 1'b0;
                    flags_reg      <= {ula_Z, ula_C, ula_S, ula_O};
                    if (~&contador_ops)
                        contador_ops <= contador_ops + UM;
                    estado <= RESPONDE;
                end
                RESPONDE: begin
                    if (resp_pronto)
                        estado <= OCIOSO;
                end
                default: estado <= OCIOSO;
            endcase
        end
    end

endmodule

// File: tb/tb_ula_sequenciador.sv
// Bench for ula_sequenciador: directed steps plus random ops vs a reference model.
// Chaining steps compile only with ULA_SEQ_ENCADEAR_EN defined.
module tb_ula_sequenciador;

    localparam int W = 16;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          req_valido;
    logic          req_pronto;
    logic [4:0]    req_controle;
    logic [W-1:0]  req_opA;
    logic [W-1:0]  req_opB;
    logic          req_encadear;
    logic [W-1:0]  ula_operandoA;
    logic [W-1:0]  ula_operandoB;
    logic [4:0]    ula_controle;
    logic [W-1:0]  ula_resultado;
    logic          ula_Z, ula_C, ula_S, ula_O;
    logic          resp_valido;
    logic          resp_pronto;
    logic [W-1:0]  resp_resultado;
    logic [3:0]    resp_flags;
    logic          resp_erro;
    logic [3:0]    flags_reg;
    logic [15:0]   contador_ops;

    logic          s_req_pronto;
    logic [W-1:0]  s_ula_operandoA;
    logic [W-1:0]  s_ula_operandoB;
    logic [4:0]    s_ula_controle;
    logic          s_resp_valido;
    logic [W-1:0]  s_resp_resultado;
    logic [3:0]    s_resp_flags;
    logic          s_resp_erro;
    logic [3:0]    s_flags_reg;
    logic [1:0]    s_contador_ops;

    logic          stub_fix;
    logic [W-1:0]  stub_res;
    logic [3:0]    stub_flg;

    int total = 0;
    int fails = 0;

    int           m_cnt;
    logic [3:0]   m_flags;
    logic [W-1:0] m_ua, m_ub, m_last;
    logic [4:0]   m_uc;

    always #5 clock = ~clock;

    function automatic logic [W-1:0] ula_ref(
        input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] c);
        return (a + b) ^ {11'b0, c};
    endfunction

    function automatic logic [3:0] ula_flg(
        input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] c);
        logic [W:0]   s;
        logic [W-1:0] r;
        s = {1'b0, a} + {1'b0, b};
        r = s[W-1:0] ^ {11'b0, c};
        return {r == '0, s[W], r[W-1],
                (a[W-1] == b[W-1]) && (s[W-1] != a[W-1])};
    endfunction

    assign ula_resultado = stub_fix ? stub_res
                         : ula_ref(ula_operandoA, ula_operandoB, ula_controle);
    assign {ula_Z, ula_C, ula_S, ula_O} = stub_fix ? stub_flg
                         : ula_flg(ula_operandoA, ula_operandoB, ula_controle);

    ula_sequenciador #(.BITS_PALAVRA(W), .BITS_CONTADOR(16)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valido(req_valido), .req_pronto(req_pronto),
        .req_controle(req_controle), .req_opA(req_opA), .req_opB(req_opB),
`ifdef ULA_SEQ_ENCADEAR_EN
        .req_encadear(req_encadear),
`endif
        .ula_operandoA(ula_operandoA), .ula_operandoB(ula_operandoB),
        .ula_controle(ula_controle), .ula_resultado(ula_resultado),
        .ula_Z(ula_Z), .ula_C(ula_C), .ula_S(ula_S), .ula_O(ula_O),
        .resp_valido(resp_valido), .resp_pronto(resp_pronto),
        .resp_resultado(resp_resultado), .resp_flags(resp_flags),
        .resp_erro(resp_erro), .flags_reg(flags_reg),
        .contador_ops(contador_ops)
    );

    ula_sequenciador #(.BITS_PALAVRA(W), .BITS_CONTADOR(2)) dut_sat (
        .clock(clock), .reset_n(reset_n),
        .req_valido(req_valido), .req_pronto(s_req_pronto),
        .req_controle(req_controle), .req_opA(req_opA), .req_opB(req_opB),
`ifdef ULA_SEQ_ENCADEAR_EN
        .req_encadear(req_encadear),
`endif
        .ula_operandoA(s_ula_operandoA), .ula_operandoB(s_ula_operandoB),
        .ula_controle(s_ula_controle), .ula_resultado(ula_resultado),
        .ula_Z(ula_Z), .ula_C(ula_C), .ula_S(ula_S), .ula_O(ula_O),
        .resp_valido(s_resp_valido), .resp_pronto(resp_pronto),
        .resp_resultado(s_resp_resultado), .resp_flags(s_resp_flags),
        .resp_erro(s_resp_erro), .flags_reg(s_flags_reg),
        .contador_ops(s_contador_ops)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic model_reset();
        m_cnt = 0; m_flags = '0; m_last = '0;
        m_ua = '0; m_ub = '0; m_uc = '0;
    endtask

    task automatic do_op(input logic [4:0] c, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic enc,
                         input int hold);
        logic         legal;
        logic [W-1:0] ea, er;
        logic [3:0]   ef;
        legal = (c inside {5'd0, 5'd1, 5'd3, 5'd4, 5'd5, 5'd6});
        er = '0;
        ef = '0;
        req_controle = c; req_opA = a; req_opB = b;
        req_encadear = enc; req_valido = 1'b1;
        chk("req_pronto_idle", 32'(req_pronto), 32'd1);
        tick();
        req_valido = 1'b0;
        if (legal) begin
            ea = enc ? m_last : a;
            m_ua = ea; m_ub = b; m_uc = c;
            chk("ula_opA", 32'(ula_operandoA), 32'(ea));
            chk("ula_opB", 32'(ula_operandoB), 32'(b));
            chk("ula_ctl", 32'(ula_controle), 32'(c));
            chk("valid_emite", 32'(resp_valido), 32'd0);
            chk("pronto_emite", 32'(req_pronto), 32'd0);
            er = stub_fix ? stub_res : ula_ref(ea, b, c);
            ef = stub_fix ? stub_flg : ula_flg(ea, b, c);
            tick();
            m_flags = ef;
            m_last  = er;
            if (m_cnt < 65535) m_cnt++;
        end
        for (int i = 0; i <= hold; i++) begin
            if (i > 0) tick();
            chk("resp_valido", 32'(resp_valido), 32'd1);
            chk("resp_res", 32'(resp_resultado), 32'(er));
            chk("resp_flags", 32'(resp_flags), 32'(ef));
            chk("resp_erro", 32'(resp_erro), 32'(!legal));
            chk("pronto_resp", 32'(req_pronto), 32'd0);
        end
        chk("flags_reg", 32'(flags_reg), 32'(m_flags));
        chk("contador", 32'(contador_ops), 32'(m_cnt));
        chk("sat_contador", 32'(s_contador_ops),
            32'(m_cnt > 3 ? 3 : m_cnt));
        chk("sat_valido", 32'(s_resp_valido), 32'd1);
        chk("ula_opA_hold", 32'(ula_operandoA), 32'(m_ua));
        chk("ula_opB_hold", 32'(ula_operandoB), 32'(m_ub));
        chk("ula_ctl_hold", 32'(ula_controle), 32'(m_uc));
        resp_pronto = 1'b1;
        tick();
        resp_pronto = 1'b0;
        chk("valid_drop", 32'(resp_valido), 32'd0);
        chk("pronto_back", 32'(req_pronto), 32'd1);
    endtask

    initial begin
        logic [4:0] c;
        logic       enc;
        reset_n = 1'b0; req_valido = 1'b0; req_controle = '0;
        req_opA = '0; req_opB = '0; req_encadear = 1'b0;
        resp_pronto = 1'b0;
        stub_fix = 1'b1; stub_res = 16'h1234; stub_flg = 4'b0100;
        model_reset();
        tick(); tick();
        chk("rst_pronto", 32'(req_pronto), 32'd0);
        chk("rst_valido", 32'(resp_valido), 32'd0);
        chk("rst_cnt", 32'(contador_ops), 32'd0);
        chk("rst_flags", 32'(flags_reg), 32'd0);
        chk("rst_opA", 32'(ula_operandoA), 32'd0);
        reset_n = 1'b1;
        #1;
        chk("post_rst_pronto", 32'(req_pronto), 32'd1);
        tick();

        // Fixed stub result, then illegal opcode, then backpressure
        do_op(5'b00000, 16'd5, 16'd7, 1'b0, 0);
        do_op(5'b11111, 16'hAAAA, 16'h5555, 1'b0, 0);
        do_op(5'b00010, 16'h0001, 16'h0002, 1'b0, 2);
        stub_res = 16'h8000; stub_flg = 4'b0011;
        do_op(5'b00110, 16'h7FFF, 16'h0001, 1'b0, 5);

        // Saturation on the narrow instance
        stub_fix = 1'b0;
        for (int i = 0; i < 5; i++)
            do_op(5'b00001, 16'(i * 3), 16'hFFFF, 1'b0, 0);

`ifdef ULA_SEQ_ENCADEAR_EN
        stub_fix = 1'b1; stub_res = 16'h0010; stub_flg = 4'b0000;
        do_op(5'b00000, 16'h0003, 16'h0004, 1'b0, 0);
        stub_fix = 1'b0;
        do_op(5'b00011, 16'hFFFF, 16'h0002, 1'b1, 0);
        do_op(5'b11000, 16'h0000, 16'h0000, 1'b0, 0);
        do_op(5'b00100, 16'hFFFF, 16'h0001, 1'b1, 0);
`endif

        // Reset in the middle of EMITE discards the operation
        req_controle = 5'b00101; req_opA = 16'h1111; req_opB = 16'h2222;
        req_valido = 1'b1;
        tick();
        req_valido = 1'b0;
        chk("emite_valido", 32'(resp_valido), 32'd0);
        reset_n = 1'b0;
        #1;
        chk("async_rst_opA", 32'(ula_operandoA), 32'd0);
        chk("async_rst_cnt", 32'(contador_ops), 32'd0);
        tick(); tick(); tick();
        chk("rst_hold_valido", 32'(resp_valido), 32'd0);
        chk("rst_hold_flags", 32'(flags_reg), 32'd0);
        reset_n = 1'b1;
        model_reset();
        #1;
        chk("rel_pronto", 32'(req_pronto), 32'd1);
        tick();
        chk("rel_valido", 32'(resp_valido), 32'd0);
        chk("rel_resp", 32'(resp_resultado), 32'd0);

        for (int i = 0; i < 24; i++) begin
            c = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                            : 5'($urandom_range(0, 6));
            enc = 1'b0;
`ifdef ULA_SEQ_ENCADEAR_EN
            enc = 1'($urandom_range(0, 1));
`endif
            do_op(c, 16'($urandom), 16'($urandom), enc,
                  int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule

// File: doc/ula_sequenciador.md
Name: ula_sequenciador

Overview:
- Initiator side of the ULA interface: accepts operation requests over a valid/ready handshake and drives ULA operands and control from registers.
- Captures the ULA result and Z/C/S/O flags one cycle later and returns them over a valid/ready response channel.
- Keeps a persistent flag register and a completed-operation counter.
- Sits between instruction decode and the combinational ULA.

Parameters:
- BITS_PALAVRA, 16, operand/result width; must match the ULA instance.
- BITS_CONTADOR, 16, width of the operation counter.

Ports:
- clock  in  1  sole clock; rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valido  in  1  request present.
- req_pronto  out  1  sequencer can accept a request.
- req_controle  in  5  ULA operation code.
- req_opA  in  BITS_PALAVRA  operand A, signed.
- req_opB  in  BITS_PALAVRA  operand B, signed.
- ula_operandoA  out  BITS_PALAVRA  to ULA operandoA.
- ula_operandoB  out  BITS_PALAVRA  to ULA operandoB.
- ula_controle  out  5  to ULA controle.
- ula_resultado  in  BITS_PALAVRA  from ULA resultadoOp.
- ula_Z, ula_C, ula_S, ula_O  in  1 each  ULA flags.
- resp_valido  out  1  response present.
- resp_pronto  in  1  consumer accepts response.
- resp_resultado  out  BITS_PALAVRA  captured result.
- resp_flags  out  4  captured {Z,C,S,O}.
- resp_erro  out  1  request had an illegal opcode.
- flags_reg  out  4  last legal-operation flags {Z,C,S,O}.
- contador_ops  out  BITS_CONTADOR  completed legal operations, saturating.

Behaviour:
- Reset values: all outputs 0; state OCIOSO; req_pronto = 1 immediately after reset deasserts.
- Legal opcodes: 00000, 00001, 00011, 00100, 00101, 00110. All other opcodes are illegal.
- States:
  - OCIOSO: req_pronto = 1. On req_valido with a legal opcode, register opA, opB and controle onto the ula_* outputs and go to EMITE. On req_valido with an illegal opcode, ula_* outputs stay unchanged; load resp_resultado = 0, resp_flags = 0, resp_erro = 1 and go to RESPONDE.
  - EMITE: req_pronto = 0; ULA settles combinationally. At the clock edge, capture ula_resultado into resp_resultado and {ula_Z,ula_C,ula_S,ula_O} into resp_flags; set resp_erro = 0; copy the flags into flags_reg; increment contador_ops (holds at all-ones); go to RESPONDE.
  - RESPONDE: resp_valido = 1; all resp_* outputs stable. When resp_pronto = 1, go to OCIOSO; resp_valido drops the next cycle.
- Latency: request accepted at edge N; resp_valido = 1 from cycle N+2 for a legal opcode, N+1 for an illegal one.
- Throughput: one operation per 3 cycles when resp_pronto is held high.
- Requests are never accepted in the same cycle a response is consumed.
- ula_* outputs hold their last values after capture. They are not cleared on return to OCIOSO.
- Illegal opcodes leave flags_reg and contador_ops unchanged.
- Data arithmetic is entirely inside the ULA; the sequencer neither extends nor truncates it.
- reset_n asserted in any state: immediate return to OCIOSO with all outputs 0. An in-flight operation is discarded and produces no response.
- req_valido while req_pronto = 0 is ignored. Requesters must hold the request until accepted.

Optional Feature:
- Macro: ULA_SEQ_ENCADEAR_EN.
- Defined:
  - Adds input req_encadear (1 bit).
  - When set on an accepted legal request, ula_operandoA is loaded with the last legal resp_resultado instead of req_opA. This value is held in an internal register, reset 0.
  - Illegal requests do not update that register.
- Undefined: the port is absent and operand A always comes from req_opA.

Test Plan:
- Reset: hold reset_n = 0 for 3 cycles mid-EMITE -> all outputs 0, req_pronto = 1 after release, no resp_valido.
- Legal op with ULA stub: stub returns resultado = 16'h1234, Z=0 C=1 S=0 O=0; request controle = 00000, opA = 5, opB = 7 -> ula_operandoA = 5, ula_operandoB = 7 at N+1; resp_valido at N+2 with resp_resultado = 16'h1234, resp_flags = 4'b0100, flags_reg = 4'b0100, contador_ops = 1.
- Illegal op: controle = 11111 -> resp_valido at N+1, resp_erro = 1, resp_resultado = 0; flags_reg and contador_ops unchanged; ula_* outputs unchanged.
- Backpressure: resp_pronto = 0 for 5 cycles -> resp_* stable, req_pronto = 0 throughout; resp_pronto = 1 -> back to OCIOSO next cycle.
- Saturation: BITS_CONTADOR = 2, run 5 legal ops -> contador_ops stays 3.
- ULA_SEQ_ENCADEAR_EN: op1 stub result 16'h0010, then op2 with req_encadear = 1 and opA = 16'hFFFF -> ula_operandoA = 16'h0010.
